fifo_sync_nbit_p: RTL and testbench
===================================

// Module: fifo_sync_Nbit_p
// PURPOSE
//  Parametrised single-clock synchronous FIFO. Storage is an inferred RAM array (DATA_W x 2**ADDR_W).
//  Generalises the fixed 8-bit x 1024 SRAM and N-bit register into a buffered queue:
//  - separate write/read ports, full/empty and threshold flags, occupancy count, overflow/underflow pulses.
//  Sits between a producer (e.g. UART/keypad sampler) and a slower consumer (FND/LED display logic).
// PARAMETERS
//  DATA_W     8            data width in bits
//  ADDR_W     4            address width; DEPTH = 2**ADDR_W entries
//  AFULL_LVL  2**ADDR_W-2  almost_full asserts when count >= AFULL_LVL
//  AEMPTY_LVL 2            almost_empty asserts when count <= AEMPTY_LVL
// PORTS
//  clk           in   1         system clock, all logic on posedge
//  reset_p       in   1         synchronous active-high reset
//  wr_en         in   1         write request
//  wr_data       in   DATA_W    write data, sampled when the write is accepted
//  rd_en         in   1         read request
//  rd_data       out  DATA_W    read data, registered
//  rd_valid      out  1         1-cycle pulse: rd_data holds a newly popped word
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  almost_full   out  1         count >= AFULL_LVL
//  almost_empty  out  1         count <= AEMPTY_LVL
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow      out  1         1-cycle pulse: write rejected
//  underflow     out  1         1-cycle pulse: read rejected
// BEHAVIOUR
//  Clock and reset
//  - One clock, clk. reset_p is synchronous and active-high.
//  - Reset (sampled high at posedge) clears wr_ptr, rd_ptr, count, rd_data(=0), rd_valid, overflow, underflow.
//  - After reset: empty=1, almost_empty=1, full=0, almost_full=0.
//  - RAM contents are not cleared.
//  - Reset mid-operation discards all queued data. Requests in the reset cycle are ignored and flag no errors.
//  Accept rules, evaluated on the pre-edge state
//  - rd_acc = rd_en & ~empty
//  - wr_acc = wr_en & (~full | rd_acc)
//  - Full + simultaneous read and write: both are accepted, count stays DEPTH.
//  - Empty + simultaneous read and write: only the write is accepted.
//    No fall-through; underflow pulses; count -> 1.
//  Write
//  - On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1.
//  - Pointer wraps DEPTH-1 -> 0 by natural ADDR_W-bit overflow.
//  Read
//  - On rd_acc: rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps); rd_valid <= 1.
//  - Otherwise rd_valid <= 0 and rd_data holds its last value.
//  - Latency: data is visible on rd_data in the cycle after the rd_en edge.
//  Count
//  - count <= count + wr_acc - rd_acc, in ADDR_W+1 bits.
//  - It never exceeds DEPTH and never goes below 0.
//  Flags
//  - All flags are combinational from the registered count, so they are valid the cycle after the causing edge.
//  Errors
//  - overflow  <= wr_en & ~wr_acc
//  - underflow <= rd_en & ~rd_acc
//  - Both are single-cycle registered pulses, not sticky. FIFO state is unchanged by the rejected request.
//  Ordering
//  - Strict first-in first-out; no reordering or duplication.
// TESTING (bench uses DATA_W=8, ADDR_W=2 -> DEPTH=4, AFULL_LVL=2, AEMPTY_LVL=2)
//  1. Reset, then idle -> count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=8'h00.
//  2. Write 11,22,33,44 on consecutive cycles -> count 1,2,3,4; almost_full from count=2; full=1 after the 4th write.
//     A 5th write of 55 -> overflow pulse, count stays 4.
//  3. From full, read 4 times -> rd_data 11,22,33,44 with rd_valid, each 1 cycle after rd_en; empty=1 at end.
//     A 5th read -> underflow pulse, rd_data holds 44.
//  4. Full + wr_en=rd_en=1 (wr_data=A5) -> rd_data=11, no overflow, count=4.
//     Drain -> 22,33,44,A5 (wrap-around of both pointers).
//  5. Empty + wr_en=rd_en=1 (wr_data=5A) -> underflow pulse, count=1, rd_valid=0.
//     Next-cycle read -> rd_data=5A.
//  6. count=3, assert reset_p one cycle together with wr_en and rd_en -> count=0, empty=1, no error pulses.
//     Then write 77 and read it -> rd_data=77.

Source files
------------

// File: rtl/fifo_sync_nbit_p.sv
// Single-clock synchronous FIFO with an inferred RAM array, a registered read port,
// occupancy flags and single-cycle overflow/underflow pulses.
module fifo_sync_nbit_p #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned AFULL_LVL  = (2**ADDR_W) - 2,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    // Accept decisions use the pre-edge occupancy; a read frees a slot for a write to a full FIFO.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AFULL_LVL));
    assign almost_empty = (count <= CNT_W'(AEMPTY_LVL));

    // Storage is left unreset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (!reset_p && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
            count     <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_nbit_p.sv
// Bench for fifo_sync_nbit_p: directed corner cases then random traffic, all
// checked against a queue-based reference model.
module tb_fifo_sync_nbit_p;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_p;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rd_valid;
    logic              m_ovf;
    logic              m_udf;

    fifo_sync_nbit_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(2), .AEMPTY_LVL(2)
    ) dut (
        .clk(clk), .reset_p(reset_p), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of requests, advance the model by the FIFO rules, then compare everything.
    task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d, input logic rd);
        bit racc, wacc;
        reset_p = r; wr_en = w; wr_data = d; rd_en = rd;
        if (r) begin
            q.delete();
            m_rd_data = '0; m_rd_valid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            racc = rd && (q.size() > 0);
            wacc = w && ((q.size() < DEPTH) || racc);
            m_rd_valid = racc;
            m_ovf = w && !wacc;
            m_udf = rd && !racc;
            if (racc) m_rd_data = q.pop_front();
            if (wacc) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check("rd_data",      32'(rd_data),      32'(m_rd_data));
        check("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("count",        32'(count),        32'(q.size()));
        check("full",         32'(full),         32'(q.size() == DEPTH));
        check("empty",        32'(empty),        32'(q.size() == 0));
        check("almost_full",  32'(almost_full),  32'(q.size() >= 2));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    endtask

    initial begin
        reset_p = 1; wr_en = 0; wr_data = '0; rd_en = 0;
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        // Fill past full, then drain past empty.
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 0);
        step(0, 1, 8'h55, 0);
        check("hold_after_ovf", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
        check("hold_after_udf", 32'(rd_data), 32'h44);
        // Full with simultaneous read and write, then drain across the wrap.
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 0);
        step(0, 1, 8'hA5, 1);
        check("full_rw_data", 32'(rd_data), 32'h11);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
        check("wrap_last", 32'(rd_data), 32'hA5);
        // Empty with simultaneous read and write: no fall-through.
        step(0, 1, 8'h5A, 1);
        check("empty_rw_count", 32'(count), 32'd1);
        step(0, 0, 8'h00, 1);
        check("empty_rw_data", 32'(rd_data), 32'h5A);
        // Reset mid-operation with requests present.
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h03, 0);
        step(1, 1, 8'h04, 1);
        step(0, 1, 8'h77, 0);
        step(0, 0, 8'h00, 1);
        check("post_reset_data", 32'(rd_data), 32'h77);
        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < 55),
                 DATA_W'($urandom),
                 ($urandom_range(0, 99) < 50));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
